// File: rtl/mips_mc_controller_if.sv
// +-----------------------------------------------------------------------------
// | mips_mc_controller_if : instruction fields in, datapath controls out
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

interface mips_mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] ALUControl;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic       IorD;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       PCEn;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output ALUControl, ALUSrcA, ALUSrcB, PCSrc, IorD, IRWrite,
           MemWrite, RegWrite, RegDst, MemtoReg, PCEn, state
  );

  modport slave (
    output op, funct, zero,
    input  ALUControl, ALUSrcA, ALUSrcB, PCSrc, IorD, IRWrite,
           MemWrite, RegWrite, RegDst, MemtoReg, PCEn, state
  );
endinterface

`default_nettype wire

// File: rtl/mips_mc_controller.sv
// +-----------------------------------------------------------------------------
// | mips_mc_controller : multicycle MIPS control FSM with ALU control decode
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module mips_mc_controller (
  input  logic                         clk,
  input  logic                         rst_n,
  mips_mc_controller_if.master         bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e     state_q, state_d;
  logic [1:0] alu_op;
  logic [2:0] alu_ctrl;
  logic       pc_write, branch;
  logic       alu_src_a, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, i_or_d;
  logic [1:0] alu_src_b, pc_src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    alu_op     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        i_or_d  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // ALUOp 11 is never produced; it falls through to ADD like unknown functs.
  always_comb begin
    alu_ctrl = 3'b010;
    case (alu_op)
      2'b01: alu_ctrl = 3'b110;
      2'b10: begin
        case (bus.funct)
          6'b100010: alu_ctrl = 3'b110;
          6'b100100: alu_ctrl = 3'b000;
          6'b100101: alu_ctrl = 3'b001;
          6'b101010: alu_ctrl = 3'b111;
          default:   alu_ctrl = 3'b010;
        endcase
      end
      default: alu_ctrl = 3'b010;
    endcase
  end

  assign bus.ALUControl = alu_ctrl;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.PCSrc      = pc_src;
  assign bus.IorD       = i_or_d;
  assign bus.IRWrite    = ir_write;
  assign bus.MemWrite   = mem_write;
  assign bus.RegWrite   = reg_write;
  assign bus.RegDst     = reg_dst;
  assign bus.MemtoReg   = mem_to_reg;
  assign bus.PCEn       = pc_write | (branch & bus.zero);
  assign bus.state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_controller.sv
// +-----------------------------------------------------------------------------
// | tb_mips_mc_controller : directed self-checking bench for the control FSM
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_mips_mc_controller;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  mips_mc_controller_if bus ();

  mips_mc_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // seq is packed MSB-first, one state per nibble; starts and ends in FETCH.
  task automatic run_seq(input string name, input logic [5:0] op, input logic [23:0] seq, input int n);
    logic [3:0] s;
    bus.op = op;
    for (int i = 0; i < n; i++) begin
      s = seq[23-4*i -: 4];
      check_eq({name, " state"}, 8'(bus.state), 8'(s));
      check_eq({name, " MemWrite"}, 8'(bus.MemWrite), 8'(s == 4'd5));
      check_eq({name, " RegWrite"}, 8'(bus.RegWrite), 8'(s == 4'd4 || s == 4'd7 || s == 4'd10));
      if (i != n - 1) step();
    end
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [2:0] exp_alu);
    bus.op    = 6'b000000;
    bus.funct = fn;
    check_eq("rtype fetch", 8'(bus.state), 8'd0);
    step();
    check_eq("rtype decode", 8'(bus.state), 8'd1);
    step();
    check_eq("rtype execute", 8'(bus.state), 8'd6);
    check_eq("rtype ALUControl", 8'(bus.ALUControl), 8'(exp_alu));
    check_eq("rtype ALUSrcA", 8'(bus.ALUSrcA), 8'd1);
    check_eq("rtype ALUSrcB", 8'(bus.ALUSrcB), 8'd0);
    step();
    check_eq("rtype aluwb", 8'(bus.state), 8'd7);
    check_eq("rtype RegDst", 8'(bus.RegDst), 8'd1);
    check_eq("rtype RegWrite", 8'(bus.RegWrite), 8'd1);
    step();
  endtask

  task automatic beq(input logic z);
    bus.op   = 6'b000100;
    bus.zero = z;
    check_eq("beq fetch", 8'(bus.state), 8'd0);
    step();
    check_eq("beq decode PCEn", 8'(bus.PCEn), 8'd0);
    step();
    check_eq("beq state", 8'(bus.state), 8'd8);
    check_eq("beq PCEn", 8'(bus.PCEn), 8'(z));
    check_eq("beq ALUControl", 8'(bus.ALUControl), 8'b110);
    check_eq("beq PCSrc", 8'(bus.PCSrc), 8'b01);
    step();
    check_eq("beq return", 8'(bus.state), 8'd0);
    bus.zero = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    bus.op    = 6'b100011;
    bus.funct = 6'b000000;
    bus.zero  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset state", 8'(bus.state), 8'd0);
    check_eq("reset PCEn", 8'(bus.PCEn), 8'd1);
    check_eq("reset IRWrite", 8'(bus.IRWrite), 8'd1);
    check_eq("reset ALUControl", 8'(bus.ALUControl), 8'b010);
    check_eq("reset ALUSrcB", 8'(bus.ALUSrcB), 8'b01);
    check_eq("reset RegWrite", 8'(bus.RegWrite), 8'd0);

    rst_n = 1'b1;
    step();
    check_eq("release decode", 8'(bus.state), 8'd1);
    check_eq("decode ALUSrcB", 8'(bus.ALUSrcB), 8'b11);
    step();
    check_eq("lw memadr", 8'(bus.state), 8'd2);
    check_eq("lw ALUSrcB", 8'(bus.ALUSrcB), 8'b10);
    step();
    check_eq("lw memrd", 8'(bus.state), 8'd3);
    check_eq("lw IorD", 8'(bus.IorD), 8'd1);
    step();
    check_eq("lw memwb", 8'(bus.state), 8'd4);
    check_eq("lw MemtoReg", 8'(bus.MemtoReg), 8'd1);
    check_eq("lw RegWrite", 8'(bus.RegWrite), 8'd1);
    check_eq("lw RegDst", 8'(bus.RegDst), 8'd0);
    step();
    check_eq("lw return", 8'(bus.state), 8'd0);

    run_seq("lw",   6'b100011, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0}, 6);
    run_seq("sw",   6'b101011, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0}, 5);
    run_seq("addi", 6'b001000, {4'd0, 4'd1, 4'd9, 4'd10, 4'd0, 4'd0}, 5);
    run_seq("j",    6'b000010, {4'd0, 4'd1, 4'd11, 4'd0, 4'd0, 4'd0}, 4);
    run_seq("ill",  6'b111111, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0}, 3);

    rtype(6'b100010, 3'b110);
    rtype(6'b101010, 3'b111);
    rtype(6'b100101, 3'b001);
    rtype(6'b100100, 3'b000);
    rtype(6'b100000, 3'b010);
    rtype(6'b111111, 3'b010);

    beq(1'b1);
    beq(1'b0);

    bus.op = 6'b100011;
    repeat (4) step();
    check_eq("midrst pre state", 8'(bus.state), 8'd4);
    check_eq("midrst pre RegWrite", 8'(bus.RegWrite), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst state", 8'(bus.state), 8'd0);
    check_eq("midrst RegWrite", 8'(bus.RegWrite), 8'd0);
    check_eq("midrst IRWrite", 8'(bus.IRWrite), 8'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("midrst restart", 8'(bus.state), 8'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multicycle MIPS control unit that sequences each instruction through fetch, decode, execute, memory and writeback steps. It also generates the 3-bit ALUControl code consumed by the ALU. It sits in the datapath top level: it takes the instruction opcode/funct fields and the ALU zero flag, and drives every mux select and write enable. It is the producer side of the ALU control interface; the ALU decodes exactly the codes this block emits.

## Interface
- No parameters; widths fixed by the MIPS ISA.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active-low
- op  input  6  instruction bits [31:26] from the instruction register
- funct  input  6  instruction bits [5:0]
- zero  input  1  ALU zero flag, same-cycle combinational
- ALUControl  output  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
- PCSrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg  output  1 each  datapath controls
- PCEn  output  1  PC register enable
- state  output  4  current FSM state, for debug and coverage

## Operation
- Moore FSM with 12 states. Registered state only; all outputs decode combinationally from state (plus op, funct and zero where noted).
- Every output not listed for a state is 0.
- State encoding and outputs:
  - FETCH=0: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, IRWrite=1, PCWrite=1, PCSrc=00.
  - DECODE=1: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute).
  - MEMADR=2: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD=3: IorD=1.
  - MEMWB=4: RegDst=0, MemtoReg=1, RegWrite=1.
  - MEMWR=5: IorD=1, MemWrite=1.
  - EXECUTE=6: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - ALUWB=7: RegDst=1, MemtoReg=0, RegWrite=1.
  - BRANCH=8: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1.
  - ADDIEX=9: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - ADDIWB=10: RegDst=0, MemtoReg=0, RegWrite=1.
  - JUMP=11: PCSrc=10, PCWrite=1.
- Transitions:
  - FETCH->DECODE.
  - DECODE by op: 100011 lw / 101011 sw -> MEMADR; 000000 R-type -> EXECUTE; 000100 beq -> BRANCH; 001000 addi -> ADDIEX; 000010 j -> JUMP; any other op -> FETCH.
  - MEMADR -> MEMRD if op=lw, else MEMWR.
  - MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEX->ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH.
  - Unused encodings 12-15 -> FETCH.
- ALUOp is internal, 2 bits.
  - ALUOp 00 -> ALUControl 010; 01 -> 110.
  - ALUOp 10 -> by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other funct -> 010.
  - ALUOp 11 is never generated; it decodes to 010.
  - Codes 011, 100, 101 are never emitted.
- PCEn = PCWrite | (Branch & zero), combinational.

## Timing
- Reset: asserting rst_n=0 forces state=FETCH immediately, with no clock edge required. Outputs then show the FETCH values: IRWrite=1, PCWrite=1, PCEn=1, ALUSrcB=01, ALUControl=010, all other controls 0.
- First edge after rst_n rises moves the FSM to DECODE.
- Reset mid-instruction abandons the instruction with no further write enables; the next instruction starts from FETCH.
- Cycles per instruction, FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unsupported op 2.
- op and funct are sampled in DECODE, MEMADR and EXECUTE. The instruction register holds them stable because IRWrite=1 only in FETCH.
- zero affects only PCEn, and only in BRANCH, within the same cycle.

## Test plan
- Reset: hold rst_n=0 across edges -> state=0, PCEn=1, IRWrite=1, ALUControl=010. Release rst_n -> state=1 one edge later.
- lw (op=100011) -> state sequence 0,1,2,3,4,0. Check IorD=1 in state 3 and MemtoReg=1, RegWrite=1 in state 4.
- R-type with funct 100010, 101010, 100101 -> ALUControl in EXECUTE is 110, 111, 001 respectively. State 7 shows RegDst=1, RegWrite=1. Unknown funct 111111 -> ALUControl 010.
- beq (op=000100): zero=1 -> PCEn=1 in state 8; zero=0 -> PCEn=0. ALUControl=110 in both cases. Returns to 0 after 3 cycles.
- sw, addi, j, and illegal op 111111 -> sequences 0,1,2,5,0 / 0,1,9,10,0 / 0,1,11,0 / 0,1,0. MemWrite=1 only in state 5.
- Assert rst_n=0 while in state 4 -> state=0 asynchronously, before the next clock edge. RegWrite drops to 0 at the same time.
